// File: rtl/tone_decoder.sv
// Tone decoder: locks onto a stable square-wave period on tone_i, reports the
// period, and measures how long the note lasts in tempo-scaled units.
module tone_decoder #(
  parameter  int CLK_REF    = 5000,
  parameter  int NOTE_MIN   = 21,
  parameter  int TEMP       = 8,
  parameter  int TOL        = 1,
  localparam int PERIOD_MAX = CLK_REF / NOTE_MIN,
  localparam int PW         = $clog2(PERIOD_MAX + 1),
  localparam int DW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tone_i,
  output logic [PW-1:0] period_o,
  output logic [DW-1:0] dur_o,
  output logic          note_start_o,
  output logic          note_end_o,
  output logic          active_o
);

  localparam int RANG_TEMP = CLK_REF * 4 / TEMP;
  localparam int TW        = $clog2(RANG_TEMP + 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q, prev_q;
  logic [1:0]    warm_q;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pprev_q, pprev_d;
  logic          pv_q, pv_d;
  logic [PW-1:0] period_q, period_d;
  logic [DW-1:0] dur_q, dur_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          start_q, start_d;
  logic          end_q, end_d;

  logic          edge_w;
  logic [PW-1:0] elapsed_w;
  logic          timeout_w;

  // Absolute period difference compared against the tolerance (no wrap).
  function automatic logic within_tol(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return diff <= PW'(TOL);
  endfunction

  // Duration increment that sticks at the all-ones value.
  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
    return (v == '1) ? v : v + DW'(1);
  endfunction

  // Edges are ignored until the synchroniser and history flop hold real samples.
  assign edge_w    = sync2_q & ~prev_q & (warm_q == 2'd3);
  // elapsed_w is the period P that an edge in this cycle would close.
  assign elapsed_w = cnt_q + PW'(1);
  assign timeout_w = (elapsed_w == PW'(PERIOD_MAX)) && !edge_w;

  // Period counter clears on an edge and parks at the timeout value otherwise.
  always_comb begin
    cnt_d = elapsed_w;
    if (edge_w) begin
      cnt_d = '0;
    end else if (elapsed_w == PW'(PERIOD_MAX)) begin
      cnt_d = cnt_q;
    end
  end

  // Next-state and output decode for the acquire/track FSM and duration logic.
  always_comb begin
    state_d  = state_q;
    pprev_d  = pprev_q;
    pv_d     = pv_q;
    period_d = period_q;
    dur_d    = dur_q;
    tick_d   = tick_q;
    start_d  = 1'b0;
    end_d    = 1'b0;
    // Tick runs every TRACK cycle, including the one that ends the note.
    if (state_q == TRACK) begin
      if (tick_q == TW'(RANG_TEMP - 1)) begin
        tick_d = '0;
        dur_d  = sat_inc(dur_q);
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end
    case (state_q)
      IDLE: begin
        if (edge_w) begin
          state_d = ACQUIRE;
          pv_d    = 1'b0;
        end
      end
      ACQUIRE: begin
        if (edge_w) begin
          if (pv_q && within_tol(elapsed_w, pprev_q)) begin
            state_d  = TRACK;
            period_d = elapsed_w;
            start_d  = 1'b1;
            dur_d    = '0;
            tick_d   = '0;
          end
          pprev_d = elapsed_w;
          pv_d    = 1'b1;
        end else if (timeout_w) begin
          state_d = IDLE;
        end
      end
      TRACK: begin
        // Jitter inside the tolerance keeps the locked period untouched.
        if (edge_w) begin
          if (!within_tol(elapsed_w, period_q)) begin
            state_d = ACQUIRE;
            end_d   = 1'b1;
            pprev_d = elapsed_w;
            pv_d    = 1'b1;
          end
        end else if (timeout_w) begin
          state_d = IDLE;
          end_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Synchroniser, edge history and warm-up counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      warm_q  <= 2'd0;
    end else begin
      sync1_q <= tone_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  // FSM, period/duration state and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pprev_q  <= '0;
      pv_q     <= 1'b0;
      period_q <= '0;
      dur_q    <= '0;
      tick_q   <= '0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pprev_q  <= pprev_d;
      pv_q     <= pv_d;
      period_q <= period_d;
      dur_q    <= dur_d;
      tick_q   <= tick_d;
      start_q  <= start_d;
      end_q    <= end_d;
    end
  end

  assign period_o     = period_q;
  assign dur_o        = dur_q;
  assign note_start_o = start_q;
  assign note_end_o   = end_q;
  assign active_o     = (state_q == TRACK);

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder: directed tone patterns, expected note events queued
// up front and matched by a monitor whenever a start/end pulse appears.
module tb_tone_decoder;

  localparam int CLK_REF  = 5000;
  localparam int NOTE_MIN = 21;
  // Shorter duration unit (125 clocks) so saturation fits in a short run.
  localparam int TEMP     = 160;
  localparam int TOL      = 1;
  localparam int PW       = $clog2(CLK_REF / NOTE_MIN + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tone = 1'b0;
  logic [PW-1:0] period_o;
  logic [7:0]    dur_o;
  logic          note_start_o, note_end_o, active_o;

  typedef struct {
    bit is_end;
    int period;
    int dur;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  total = 0;
  int  bad   = 0;

  tone_decoder #(
    .CLK_REF (CLK_REF),
    .NOTE_MIN(NOTE_MIN),
    .TEMP    (TEMP),
    .TOL     (TOL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tone_i      (tone),
    .period_o    (period_o),
    .dur_o       (dur_o),
    .note_start_o(note_start_o),
    .note_end_o  (note_end_o),
    .active_o    (active_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  // One tone cycle of n clocks measured rise to next rise.
  task automatic pulse(input int n);
    tone = 1'b1;
    repeat (n / 2) tk();
    tone = 1'b0;
    repeat (n - n / 2) tk();
  endtask

  // Closing rising edge so the last period is delimited, then silence.
  task automatic final_rise();
    tone = 1'b1;
    repeat (4) tk();
    tone = 1'b0;
  endtask

  task automatic expect_ev(input bit is_end, input int p, input int d);
    ev_t e;
    e.is_end = is_end;
    e.period = p;
    e.dur    = d;
    exp_q.push_back(e);
  endtask

  task automatic settle(input string name);
    repeat (300) tk();
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_active"}, int'(active_o), 0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_period"}, int'(period_o), 0);
    chk({name, "_dur"}, int'(dur_o), 0);
    chk({name, "_start"}, int'(note_start_o), 0);
    chk({name, "_end"}, int'(note_end_o), 0);
    chk({name, "_active"}, int'(active_o), 0);
  endtask

  // Monitor: every start/end pulse must match the next queued event.
  always @(negedge clk) begin
    if (!rst && (note_start_o || note_end_o)) begin
      chk("pulse_exclusive", int'(note_start_o & note_end_o), 0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: start=%0d end=%0d period=%0d, none queued",
                 note_start_o, note_end_o, period_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_kind_end", int'(note_end_o), int'(mon_e.is_end));
        chk("event_period", int'(period_o), mon_e.period);
        chk("event_dur", int'(dur_o), mon_e.dur);
        chk("event_active", int'(active_o), mon_e.is_end ? 0 : 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gaps[6] = '{16, 16, 17, 16, 15, 16};
    rst  = 1'b1;
    tone = 1'b0;
    repeat (3) tk();
    chk_zero("reset");
    rst = 1'b0;
    repeat (5) tk();

    // Steady 16-clock tone for ~5000 clocks.
    expect_ev(1'b0, 16, 0);
    expect_ev(1'b1, 16, 41);
    repeat (312) pulse(16);
    final_rise();
    settle("steady16");
    chk("steady16_period_hold", int'(period_o), 16);
    chk("steady16_dur_hold", int'(dur_o), 41);

    // Jitter within tolerance after lock.
    expect_ev(1'b0, 16, 0);
    expect_ev(1'b1, 16, 2);
    foreach (gaps[i]) pulse(gaps[i]);
    final_rise();
    settle("jitter");
    chk("jitter_period_hold", int'(period_o), 16);

    // Period change 16 -> 40.
    expect_ev(1'b0, 16, 0);
    expect_ev(1'b1, 16, 2);
    expect_ev(1'b0, 40, 0);
    expect_ev(1'b1, 40, 3);
    repeat (20) pulse(16);
    repeat (6) pulse(40);
    final_rise();
    settle("change");

    // Longest period locks; one clock longer never does.
    expect_ev(1'b0, 238, 0);
    expect_ev(1'b1, 238, 7);
    repeat (5) pulse(238);
    repeat (4) pulse(239);
    settle("boundary");

    // Reset in the middle of a tracked note.
    expect_ev(1'b0, 16, 0);
    repeat (8) pulse(16);
    chk("pre_reset_active", int'(active_o), 1);
    #2 rst = 1'b1;
    #1 chk_zero("mid_reset");
    repeat (3) tk();
    rst = 1'b0;
    repeat (5) tk();
    expect_ev(1'b0, 16, 0);
    expect_ev(1'b1, 16, 2);
    repeat (6) pulse(16);
    final_rise();
    settle("relock");

    // Long note saturates the duration.
    expect_ev(1'b0, 20, 0);
    expect_ev(1'b1, 20, 255);
    repeat (1750) pulse(20);
    final_rise();
    settle("saturate");
    chk("saturate_dur_hold", int'(dur_o), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_decoder.md
TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 Parameter CLK_REF, default 5000: clk cycles per time-base unit.
REQ-002 Parameter NOTE_MIN, default 21: lowest detectable tone in Hz; PERIOD_MAX = CLK_REF/NOTE_MIN (238 clocks at defaults).
REQ-003 Parameter TEMP, default 8: tempo divisor; RANG_TEMP = CLK_REF*4/TEMP clocks per duration unit (2500 at defaults).
REQ-004 Parameter TOL, default 1: maximum period difference, in clocks, between consecutive periods of one note.
REQ-005 Derived widths: PW = $clog2(PERIOD_MAX+1) for periods; DW = 8 for durations.
REQ-006 clk  input  1  single system clock; all logic is on its rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 tone_i  input  1  square-wave tone from the buzzer line, asynchronous to clk.
REQ-009 period_o  output  PW  measured tone period in clk cycles, held between updates.
REQ-010 dur_o  output  DW  note duration in RANG_TEMP units, valid on note_end_o and held afterwards.
REQ-011 note_start_o  output  1  one-cycle pulse when a stable note is locked.
REQ-012 note_end_o  output  1  one-cycle pulse when a locked note ends.
REQ-013 active_o  output  1  high while a note is locked.

Function
REQ-014 tone_i passes through a 2-flop synchroniser; a rising edge is detected in the cycle where the synchronised value is 1 and its previous value was 0.
REQ-015 The period counter clears on each detected edge and increments every clock; P = clocks between consecutive detected edges (minimum 2).
REQ-016 Timeout: counter reaches PERIOD_MAX with no edge; an edge in that same cycle takes precedence and gives valid P = PERIOD_MAX.
REQ-017 FSM states: IDLE, ACQUIRE, TRACK.
REQ-018 IDLE: first edge -> ACQUIRE with counter cleared; no P is produced.
REQ-019 ACQUIRE: each edge stores P as P_prev; when |P - P_prev| <= TOL -> TRACK, period_o = P, note_start_o pulses in the same cycle, and the duration logic clears.
REQ-020 ACQUIRE: timeout -> IDLE with no pulses.
REQ-021 TRACK: edge with |P - period_o| <= TOL -> stay; period_o is not updated, so jitter within TOL cannot drift it.
REQ-022 TRACK: edge with |P - period_o| > TOL -> ACQUIRE, note_end_o pulses, and P becomes P_prev.
REQ-023 TRACK: timeout -> IDLE and note_end_o pulses.
REQ-024 The duration tick counter counts 0..RANG_TEMP-1 only in TRACK; on wrap, dur_o increments and saturates at 255.
REQ-025 A tick in the same cycle as note_end_o is included in the reported dur_o.
REQ-026 active_o is high exactly while the FSM is in TRACK.
REQ-027 note_start_o and note_end_o are never both high in the same cycle.
REQ-028 period_o and dur_o hold their last values after note_end_o until the next note_start_o.
REQ-029 All arithmetic is unsigned; period comparison uses the absolute difference, with no wrap-around.

Reset
REQ-030 While rst is high: FSM = IDLE, synchroniser and all counters = 0, period_o = 0, dur_o = 0, all pulses and active_o = 0.
REQ-031 Reset asserted mid-note aborts the note without a note_end_o pulse.
REQ-032 After rst deasserts, the first edge is not counted until the synchroniser has two valid samples.

Verification
REQ-033 Square wave, period 16 clocks, for 5000 clocks, then low -> note_start_o once with period_o = 16; note_end_o once about 238 clocks after the last edge with dur_o = 2; active_o low afterwards.
REQ-034 Periods 16,17,16,15,16 -> note locked at 16; no note_end_o before timeout; period_o stays 16.
REQ-035 Period 16 (20 cycles), then period 40 -> note_end_o, then note_start_o with period_o = 40, separated by at least 2 edges.
REQ-036 Period 238, then period 239 -> period 238 locks; period 239 produces timeout, IDLE, and no lock.
REQ-037 rst pulsed mid-TRACK -> all outputs 0 within the reset cycle; no note_end_o; relock after 3 edges.
REQ-038 Tone held 700000 clocks at period 20 -> dur_o saturates at 255 on note_end_o.
